// File: rtl/pim_mac_tile.sv
// Streaming CHUNK_SIZE x CHUNK_SIZE MAC tile: accumulates one k-slice of A/B per accepted beat.
// Optional build macro PIM_MAC_SATURATE_EN: saturating accumulation with a sticky overflow flag.
module pim_mac_tile #(
    parameter int ID         = 0,
    parameter int WIDTH      = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int CHUNK_SIZE = 4,
    parameter int K_DEPTH    = 8
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [CHUNK_SIZE-1:0][WIDTH-1:0]                a_col,
    input  logic [CHUNK_SIZE-1:0][WIDTH-1:0]                b_row,
    output logic [CHUNK_SIZE*CHUNK_SIZE-1:0][ACC_WIDTH-1:0] result,
    output logic                                            result_valid,
    input  logic                                            result_ready,
    output logic                                            busy,
    output logic                                            overflow,
    output logic [31:0]                                     tile_id
);

    localparam int N_ELEM = CHUNK_SIZE * CHUNK_SIZE;
    localparam int CNT_W  = $clog2(K_DEPTH) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]                        state_q, state_d;
    logic [CNT_W-1:0]                  beat_cnt_q, beat_cnt_d;
    logic [N_ELEM-1:0][ACC_WIDTH-1:0]  acc_q, acc_d, mac_val;
    logic                              accept;
    logic                              load;

    assign in_ready     = (state_q != ST_DONE);
    assign busy         = (state_q != ST_IDLE);
    assign result_valid = (state_q == ST_DONE);
    assign result       = acc_q;
    assign tile_id      = 32'(ID);
    assign accept       = in_valid && in_ready;
    // The first beat of a tile overwrites the accumulator rather than adding to it.
    assign load         = (state_q == ST_IDLE);

`ifdef PIM_MAC_SATURATE_EN
    logic [N_ELEM-1:0] clip;
`endif

    for (genvar i = 0; i < CHUNK_SIZE; i++) begin : g_row
        for (genvar j = 0; j < CHUNK_SIZE; j++) begin : g_col
            localparam int E = i * CHUNK_SIZE + j;
            logic [2*WIDTH-1:0]   prod;
            logic [ACC_WIDTH-1:0] base;

            assign prod = (2*WIDTH)'(a_col[i]) * (2*WIDTH)'(b_row[j]);
            assign base = load ? '0 : acc_q[E];
`ifdef PIM_MAC_SATURATE_EN
            logic [ACC_WIDTH:0] sum;
            assign sum        = {1'b0, base} + (ACC_WIDTH+1)'(prod);
            assign clip[E]    = sum[ACC_WIDTH];
            assign mac_val[E] = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
            assign mac_val[E] = base + ACC_WIDTH'(prod);
`endif
        end
    end

    always_comb begin
        // NOTE: every next-state variable takes its hold value first, so no path leaves one unassigned (no latches).
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        acc_d      = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    acc_d      = mac_val;
                    beat_cnt_d = CNT_W'(1);
                    state_d    = (K_DEPTH == 1) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    acc_d      = mac_val;
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == CNT_W'(K_DEPTH - 1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    state_d    = ST_IDLE;
                    beat_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // NOTE: the accumulator array is cleared on reset because result is visible (and must read 0) straight out of reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            acc_q      <= acc_d;
        end
    end

`ifdef PIM_MAC_SATURATE_EN
    logic overflow_q, overflow_d;

    // Sticky within a tile; the first beat of the next tile restarts it.
    always_comb begin
        overflow_d = overflow_q;
        if (accept) overflow_d = (load ? 1'b0 : overflow_q) | (|clip);
    end

    always_ff @(posedge clk) begin
        if (rst) overflow_q <= 1'b0;
        else     overflow_q <= overflow_d;
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule
